serving_wb_ram_bridge: RTL and testbench

SERVING_WB_RAM_BRIDGE -- requirements
Module: serving_wb_ram_bridge

---
 rtl/serving_wb_ram_bridge.sv | 136 +++++++++++++
 tb/tb_serving_wb_ram_bridge.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/serving_wb_ram_bridge.sv
// serving_wb_ram_bridge: adapts a 32-bit Wishbone classic slave port onto a
// byte-wide RAM with a registered (1-cycle latency) read port. Each word
// access is split into four sequential byte accesses, lowest byte first.
module serving_wb_ram_bridge #(
  parameter int aw = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [aw-1:0] i_wb_adr,
  input  logic [31:0]   i_wb_dat,
  input  logic [3:0]    i_wb_sel,
  input  logic          i_wb_we,
  input  logic          i_wb_cyc,
  output logic [31:0]   o_wb_rdt,
  output logic          o_wb_ack,
  output logic [aw-1:0] o_waddr,
  output logic [7:0]    o_wdata,
  output logic          o_wen,
  output logic [aw-1:0] o_raddr,
  output logic          o_ren,
  input  logic [7:0]    i_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t state, state_nxt;
  logic [1:0] cnt, cnt_nxt;
  logic       latch;

  // Latched request. The word address drops the two byte-lane bits; the
  // byte counter supplies them during the sequence, so there is never a
  // carry into the word address. Direction is carried by WRITE vs READ.
  logic [aw-3:0]   adr_q;
  logic [3:0][7:0] dat_q;
  logic [3:0]      sel_q;

  // Read-capture pipeline: one stage matching the RAM read latency.
  logic            rvalid;
  logic [1:0]      ridx;
  logic [3:0][7:0] rdt_q;

  // Byte-lane address bits are architecturally ignored.
  logic unused_adr_lsb;
  assign unused_adr_lsb = ^i_wb_adr[1:0];

  // State and byte-counter register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      cnt   <= 2'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Request capture; only loaded when IDLE accepts a new cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      adr_q <= '0;
      dat_q <= '0;
      sel_q <= '0;
    end else if (latch) begin
      adr_q <= i_wb_adr[aw-1:2];
      dat_q <= i_wb_dat;
      sel_q <= i_wb_sel;
    end
  end

  // Next-state and RAM-side outputs; everything idles at zero outside
  // WRITE/READ so reset leaves all outputs low.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    latch     = 1'b0;
    o_waddr   = '0;
    o_wdata   = '0;
    o_wen     = 1'b0;
    o_raddr   = '0;
    o_ren     = 1'b0;
    o_wb_ack  = 1'b0;
    case (state)
      IDLE: begin
        if (i_wb_cyc) begin
          latch     = 1'b1;
          cnt_nxt   = 2'd0;
          state_nxt = i_wb_we ? WRITE : READ;
        end
      end
      WRITE: begin
        o_waddr = {adr_q, cnt};
        o_wdata = dat_q[cnt];
        o_wen   = sel_q[cnt];
        cnt_nxt = cnt + 2'd1;
        if (cnt == 2'd3) state_nxt = ACK;
      end
      READ: begin
        o_raddr = {adr_q, cnt};
        o_ren   = 1'b1;
        cnt_nxt = cnt + 2'd1;
        if (cnt == 2'd3) state_nxt = ACK;
      end
      ACK: begin
        // A read reaches ACK while its last byte is still in flight from
        // the RAM; hold off the ack one cycle until it has been captured.
        if (!rvalid) begin
          o_wb_ack  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture each read byte one cycle after its read enable, into the lane
  // given by the counter value that issued it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rvalid <= 1'b0;
      ridx   <= 2'd0;
      rdt_q  <= '0;
    end else begin
      rvalid <= o_ren;
      ridx   <= cnt;
      if (rvalid) rdt_q[ridx] <= i_rdata;
    end
  end

  assign o_wb_rdt = rdt_q;

endmodule

// File: tb/tb_serving_wb_ram_bridge.sv
// Bench for serving_wb_ram_bridge: byte RAM model with registered read, a
// shadow memory for expected read data, and queues of expected RAM beats
// and acks that a negedge monitor pops as the DUT produces them.
module tb_serving_wb_ram_bridge;
  localparam int AW    = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          rst;
  logic [AW-1:0] wb_adr;
  logic [31:0]   wb_dat;
  logic [3:0]    wb_sel;
  logic          wb_we;
  logic          wb_cyc;
  logic [31:0]   wb_rdt;
  logic          wb_ack;
  logic [AW-1:0] waddr;
  logic [7:0]    wdata;
  logic          wen;
  logic [AW-1:0] raddr;
  logic          ren;
  logic [7:0]    rdata;

  serving_wb_ram_bridge #(.aw(AW)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_wb_adr(wb_adr), .i_wb_dat(wb_dat), .i_wb_sel(wb_sel),
    .i_wb_we(wb_we), .i_wb_cyc(wb_cyc),
    .o_wb_rdt(wb_rdt), .o_wb_ack(wb_ack),
    .o_waddr(waddr), .o_wdata(wdata), .o_wen(wen),
    .o_raddr(raddr), .o_ren(ren), .i_rdata(rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  // RAM model driven only by the DUT's RAM port.
  logic [7:0] ram [0:DEPTH-1];
  logic       preload;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= 8'hFF;
    end else begin
      if (wen) ram[waddr] <= wdata;
      if (ren) rdata <= ram[raddr];
    end
  end

  // Shadow memory updated from stimulus, independent of the DUT.
  logic [7:0] ref_mem [0:DEPTH-1];

  typedef struct { int cyc; logic [31:0] a; logic [31:0] d; } beat_t;
  typedef struct { int cyc; bit rd; logic [31:0] d; } ack_t;
  beat_t exp_wr[$];
  beat_t exp_rd[$];
  ack_t  exp_ack[$];

  int n_cmp = 0;
  int n_err = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  // Push the expected RAM beats and ack for a request first seen in cycle n.
  task automatic push_req(input bit we, input logic [AW-1:0] adr,
                          input logic [31:0] dat, input logic [3:0] sel, input int n);
    logic [AW-1:0] base;
    logic [31:0]   rd;
    base = {adr[AW-1:2], 2'b00};
    rd   = '0;
    for (int k = 0; k < 4; k++) begin
      if (we) begin
        if (sel[k]) begin
          exp_wr.push_back('{n + 1 + k, 32'(base + AW'(k)), 32'(dat[8*k +: 8])});
          ref_mem[base + AW'(k)] = dat[8*k +: 8];
        end
      end else begin
        exp_rd.push_back('{n + 1 + k, 32'(base + AW'(k)), 32'd0});
        rd[8*k +: 8] = ref_mem[base + AW'(k)];
      end
    end
    if (we) exp_ack.push_back('{n + 5, 1'b0, 32'd0});
    else    exp_ack.push_back('{n + 6, 1'b1, rd});
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && (exp_wr.size() + exp_rd.size() + exp_ack.size()) > 0; i++) begin
      @(posedge clk); #1;
    end
    chk("drain", 32'(exp_wr.size() + exp_rd.size() + exp_ack.size()), 32'd0);
  endtask

  task automatic do_req(input bit we, input logic [AW-1:0] adr,
                        input logic [31:0] dat, input logic [3:0] sel);
    int n;
    @(posedge clk); #1;
    n = cycle;
    wb_we = we; wb_adr = adr; wb_dat = dat; wb_sel = sel; wb_cyc = 1'b1;
    push_req(we, adr, dat, sel, n);
    @(posedge clk); #1;
    wb_cyc = 1'b0;
    wait_drain();
  endtask

  // Monitor: every RAM beat and ack must match the head of its queue.
  always @(negedge clk) begin
    beat_t b;
    ack_t  a;
    if (mon_en) begin
      chk("wen_ren_excl", {31'b0, wen & ren}, 32'd0);
      if (wen) begin
        if (exp_wr.size() == 0) chk("wen_unexp", {31'b0, wen}, 32'd0);
        else begin
          b = exp_wr.pop_front();
          chk("wr_cyc", 32'(cycle), 32'(b.cyc));
          chk("wr_addr", 32'(waddr), b.a);
          chk("wr_data", 32'(wdata), b.d);
        end
      end
      if (ren) begin
        if (exp_rd.size() == 0) chk("ren_unexp", {31'b0, ren}, 32'd0);
        else begin
          b = exp_rd.pop_front();
          chk("rd_cyc", 32'(cycle), 32'(b.cyc));
          chk("rd_addr", 32'(raddr), b.a);
        end
      end
      if (wb_ack) begin
        if (exp_ack.size() == 0) chk("ack_unexp", {31'b0, wb_ack}, 32'd0);
        else begin
          a = exp_ack.pop_front();
          chk("ack_cyc", 32'(cycle), 32'(a.cyc));
          if (a.rd) chk("ack_rdt", wb_rdt, a.d);
        end
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1; preload = 1'b1;
    wb_adr = '0; wb_dat = '0; wb_sel = '0; wb_we = 1'b0; wb_cyc = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'hFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ack",   {31'b0, wb_ack}, 32'd0);
    chk("rst_wen",   {31'b0, wen}, 32'd0);
    chk("rst_ren",   {31'b0, ren}, 32'd0);
    chk("rst_rdt",   wb_rdt, 32'd0);
    chk("rst_waddr", 32'(waddr), 32'd0);
    chk("rst_raddr", 32'(raddr), 32'd0);
    chk("rst_wdata", 32'(wdata), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; preload = 1'b0; mon_en = 1'b1;

    // Full-word write and read-back.
    do_req(1'b1, 8'h04, 32'hDEADBEEF, 4'hF);
    do_req(1'b0, 8'h04, 32'h0, 4'h0);
    chk("rd_deadbeef", wb_rdt, 32'hDEADBEEF);

    // Partial byte enables over preloaded 0xFF.
    do_req(1'b1, 8'h08, 32'h11223344, 4'b0101);
    chk("rdt_hold_wr", wb_rdt, 32'hDEADBEEF);
    do_req(1'b0, 8'h08, 32'h0, 4'hF);
    chk("rd_partial", wb_rdt, 32'hFF22FF44);

    // Unaligned address stays within its word; sel=0 writes nothing.
    do_req(1'b1, 8'h0F, 32'hA5A55A5A, 4'hF);
    do_req(1'b0, 8'h0C, 32'h0, 4'h0);
    chk("rd_unaligned", wb_rdt, 32'hA5A55A5A);
    do_req(1'b1, 8'h0F, 32'h12345678, 4'h0);
    do_req(1'b0, 8'h0F, 32'h0, 4'h0);
    chk("rd_sel0", wb_rdt, 32'hA5A55A5A);

    // Reset in the third cycle of a read: no ack, outputs clear.
    @(posedge clk); #1;
    n = cycle;
    wb_we = 1'b0; wb_adr = 8'h04; wb_cyc = 1'b1;
    exp_rd.push_back('{n + 1, 32'h04, 32'd0});
    exp_rd.push_back('{n + 2, 32'h05, 32'd0});
    @(posedge clk); #1; wb_cyc = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("abort_ack", {31'b0, wb_ack}, 32'd0);
    chk("abort_ren", {31'b0, ren}, 32'd0);
    chk("abort_raddr", 32'(raddr), 32'd0);
    chk("abort_rdt", wb_rdt, 32'd0);
    repeat (10) @(posedge clk);
    #1;
    wait_drain();
    do_req(1'b0, 8'h04, 32'h0, 4'h0);
    chk("rd_after_rst", wb_rdt, 32'hDEADBEEF);

    // Cycle held high, alternating write/read/write back to back.
    @(posedge clk); #1;
    n = cycle;
    wb_cyc = 1'b1; wb_we = 1'b1; wb_adr = 8'h20; wb_dat = 32'hCAFEF00D; wb_sel = 4'hF;
    push_req(1'b1, 8'h20, 32'hCAFEF00D, 4'hF, n);
    @(posedge clk); #1;
    wb_we = 1'b0;
    push_req(1'b0, 8'h20, 32'h0, 4'hF, n + 6);
    for (int i = 0; i < 20 && cycle < n + 7; i++) begin @(posedge clk); #1; end
    wb_we = 1'b1; wb_adr = 8'h24; wb_dat = 32'h01020304;
    push_req(1'b1, 8'h24, 32'h01020304, 4'hF, n + 13);
    for (int i = 0; i < 20 && cycle < n + 14; i++) begin @(posedge clk); #1; end
    wb_cyc = 1'b0;
    wait_drain();
    chk("b2b_rdt", wb_rdt, 32'hCAFEF00D);
    do_req(1'b0, 8'h24, 32'h0, 4'h0);

    // Random mix.
    for (int t = 0; t < 12; t++)
      do_req(1'($urandom_range(0, 1)), AW'($urandom), $urandom, 4'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
